// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the parametrised register file
package regfile_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - 1W/2R register file with walking clear; REGFILE_BYPASS_EN enables write-to-read forwarding
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b0
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [DATA_W-1:0] w,
   input  logic              rw,
   input  logic [ADDR_W-1:0] wsel,
   input  logic [ADDR_W-1:0] rsel0,
   input  logic [ADDR_W-1:0] rsel1,
   output logic [DATA_W-1:0] read0,
   output logic [DATA_W-1:0] read1,
   input  logic              clr,
   output logic              busy,
   output logic              wr_drop
);

   // One extra bit so non-power-of-two depths can be range-checked.
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wr_drop_q, wr_drop_d;
   logic              wsel_ok;
   logic              wr_en;
   logic [ADDR_W-1:0] rsel  [2];
   logic [DATA_W-1:0] rdata [2];

   always_comb begin
      wsel_ok = ({1'b0, wsel} < DEPTH_X);
      wr_en   = rw && (state_q == ST_IDLE) && wsel_ok && !(ZERO_REG && (wsel == '0));
   end

   always_comb begin
      regs_d    = regs_q;
      state_d   = state_q;
      ptr_d     = ptr_q;
      // Zero-register writes are ignored quietly; only CLEAR and bad addresses flag a drop.
      wr_drop_d = rw && ((state_q == ST_CLEAR) || !wsel_ok);
      if (state_q == ST_IDLE) begin
         if (wr_en) begin
            regs_d[wsel] = w;
         end
         if (clr) begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      end else begin
         regs_d[ptr_q] = '0;
         if (ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end else begin
            ptr_d = ptr_q + ADDR_W'(1);
         end
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_drop_q <= wr_drop_d;
      end
   end

   assign rsel[0] = rsel0;
   assign rsel[1] = rsel1;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         if (({1'b0, rsel[p]} < DEPTH_X) && !(ZERO_REG && (rsel[p] == '0))) begin
            rdata[p] = regs_q[rsel[p]];
         end
`ifdef REGFILE_BYPASS_EN
         if (wr_en && (rsel[p] == wsel)) begin
            rdata[p] = w;
         end
`endif
      end
   end

   assign read0   = rdata[0];
   assign read1   = rdata[1];
   assign busy    = (state_q == ST_CLEAR);
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - table/scoreboard bench for regfile_param across three configurations
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // default configuration: DATA_W=8, DEPTH=4
   logic       a_reset, a_rw, a_clr, a_busy, a_drop;
   logic [7:0] a_w, a_read0, a_read1;
   logic [1:0] a_wsel, a_rsel0, a_rsel1;
   // ZERO_REG=1
   logic       z_reset, z_rw, z_clr, z_busy, z_drop;
   logic [7:0] z_w, z_read0, z_read1;
   logic [1:0] z_wsel, z_rsel0, z_rsel1;
   // DATA_W=16, DEPTH=5
   logic        b_reset, b_rw, b_clr, b_busy, b_drop;
   logic [15:0] b_w, b_read0, b_read1;
   logic [2:0]  b_wsel, b_rsel0, b_rsel1;

   regfile_param u_dut (
      .sysclk(clk), .reset(a_reset), .w(a_w), .rw(a_rw), .wsel(a_wsel),
      .rsel0(a_rsel0), .rsel1(a_rsel1), .read0(a_read0), .read1(a_read1),
      .clr(a_clr), .busy(a_busy), .wr_drop(a_drop)
   );

   regfile_param #(.ZERO_REG(1'b1)) u_zr (
      .sysclk(clk), .reset(z_reset), .w(z_w), .rw(z_rw), .wsel(z_wsel),
      .rsel0(z_rsel0), .rsel1(z_rsel1), .read0(z_read0), .read1(z_read1),
      .clr(z_clr), .busy(z_busy), .wr_drop(z_drop)
   );

   regfile_param #(.DATA_W(16), .DEPTH(5)) u_wide (
      .sysclk(clk), .reset(b_reset), .w(b_w), .rw(b_rw), .wsel(b_wsel),
      .rsel0(b_rsel0), .rsel1(b_rsel1), .read0(b_read0), .read1(b_read1),
      .clr(b_clr), .busy(b_busy), .wr_drop(b_drop)
   );

   typedef struct {
      string       name;
      logic [15:0] r0, r1;
      logic        busy, drop;
   } exp_t;

   typedef struct {
      logic       rw;
      logic [1:0] wsel;
      logic [7:0] w;
      logic [1:0] rsel0, rsel1;
      logic       clr;
      logic [7:0] e0, e1;
      logic       eb, ed;
   } vec_t;

   exp_t sb[$];
   vec_t vt[17];
   int   total  = 0;
   int   passed = 0;

   function automatic vec_t mk(input logic rw, input logic [1:0] wsel, input logic [7:0] w,
                               input logic [1:0] r0, input logic [1:0] r1, input logic clr,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic eb, input logic ed);
      vec_t v;
      v.rw = rw; v.wsel = wsel; v.w = w; v.rsel0 = r0; v.rsel1 = r1; v.clr = clr;
      v.e0 = e0; v.e1 = e1; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   task automatic push_exp(input string n, input logic [15:0] r0, input logic [15:0] r1,
                           input logic eb, input logic ed);
      exp_t e;
      e.name = n; e.r0 = r0; e.r1 = r1; e.busy = eb; e.drop = ed;
      sb.push_back(e);
   endtask

   // Sampled on the falling edge, then the bench moves to just after the next rising edge.
   task automatic observe(input int dut);
      exp_t        e;
      logic [15:0] r0, r1;
      logic        b, d;
      @(negedge clk);
      case (dut)
         0:       begin r0 = 16'(a_read0); r1 = 16'(a_read1); b = a_busy; d = a_drop; end
         1:       begin r0 = 16'(z_read0); r1 = 16'(z_read1); b = z_busy; d = z_drop; end
         default: begin r0 = b_read0;      r1 = b_read1;      b = b_busy; d = b_drop; end
      endcase
      if (sb.size() == 0) begin
         total++;
         $display("FAIL scoreboard: no expectation queued for dut %0d", dut);
      end else begin
         e = sb.pop_front();
         chk({e.name, ".read0"},   r0, e.r0);
         chk({e.name, ".read1"},   r1, e.r1);
         chk({e.name, ".busy"},    16'(b), 16'(e.busy));
         chk({e.name, ".wr_drop"}, 16'(d), 16'(e.drop));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive_z(input string n, input logic rw, input logic [1:0] wsel,
                          input logic [7:0] w, input logic [1:0] r0, input logic [1:0] r1,
                          input logic [7:0] e0, input logic [7:0] e1, input logic ed);
      z_rw = rw; z_wsel = wsel; z_w = w; z_rsel0 = r0; z_rsel1 = r1; z_clr = 1'b0;
      push_exp(n, 16'(e0), 16'(e1), 1'b0, ed);
      observe(1);
   endtask

   task automatic drive_b(input string n, input logic rst, input logic rw, input logic [2:0] wsel,
                          input logic [15:0] w, input logic [2:0] r0, input logic [2:0] r1,
                          input logic clr, input logic [15:0] e0, input logic [15:0] e1,
                          input logic eb, input logic ed);
      b_reset = rst; b_rw = rw; b_wsel = wsel; b_w = w; b_rsel0 = r0; b_rsel1 = r1; b_clr = clr;
      push_exp(n, e0, e1, eb, ed);
      observe(2);
   endtask

   initial begin
      a_reset = 1'b1; a_rw = 1'b0; a_clr = 1'b0; a_w = '0; a_wsel = '0; a_rsel0 = '0; a_rsel1 = '0;
      z_reset = 1'b1; z_rw = 1'b0; z_clr = 1'b0; z_w = '0; z_wsel = '0; z_rsel0 = '0; z_rsel1 = '0;
      b_reset = 1'b1; b_rw = 1'b0; b_clr = 1'b0; b_w = '0; b_wsel = '0; b_rsel0 = '0; b_rsel1 = '0;

      //           rw    wsel  w      rs0   rs1   clr   e0                     e1     busy  drop
      vt[0]  = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b0, 8'h00,                 8'h00, 1'b0, 1'b0);
      vt[1]  = mk(1'b1, 2'd0, 8'hFF, 2'd1, 2'd2, 1'b0, 8'h00,                 8'h00, 1'b0, 1'b0);
      vt[2]  = mk(1'b1, 2'd1, 8'h3C, 2'd0, 2'd2, 1'b0, 8'hFF,                 8'h00, 1'b0, 1'b0);
      vt[3]  = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 1'b0, 8'hFF,                 8'h3C, 1'b0, 1'b0);
      vt[4]  = mk(1'b1, 2'd2, 8'hA5, 2'd2, 2'd1, 1'b0, BYP ? 8'hA5 : 8'h00,   8'h3C, 1'b0, 1'b0);
      vt[5]  = mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd2, 1'b0, 8'hA5,                 8'hA5, 1'b0, 1'b0);
      vt[6]  = mk(1'b1, 2'd3, 8'h66, 2'd3, 2'd0, 1'b0, BYP ? 8'h66 : 8'h00,   8'hFF, 1'b0, 1'b0);
      vt[7]  = mk(1'b1, 2'd0, 8'h11, 2'd1, 2'd2, 1'b0, 8'h3C,                 8'hA5, 1'b0, 1'b0);
      vt[8]  = mk(1'b1, 2'd1, 8'h22, 2'd0, 2'd3, 1'b0, 8'h11,                 8'h66, 1'b0, 1'b0);
      vt[9]  = mk(1'b1, 2'd2, 8'h33, 2'd0, 2'd1, 1'b0, 8'h11,                 8'h22, 1'b0, 1'b0);
      vt[10] = mk(1'b1, 2'd3, 8'h44, 2'd2, 2'd1, 1'b1, 8'h33,                 8'h22, 1'b0, 1'b0);
      vt[11] = mk(1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b0, 8'h11,                 8'h44, 1'b1, 1'b0);
      vt[12] = mk(1'b1, 2'd3, 8'h77, 2'd3, 2'd0, 1'b0, 8'h44,                 8'h00, 1'b1, 1'b0);
      vt[13] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b1, 8'h00,                 8'h33, 1'b1, 1'b1);
      vt[14] = mk(1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 8'h00,                 8'h44, 1'b1, 1'b0);
      vt[15] = mk(1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 1'b0, 8'h00,                 8'h00, 1'b0, 1'b0);
      vt[16] = mk(1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b0, 8'h00,                 8'h00, 1'b0, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      a_reset = 1'b0; z_reset = 1'b0; b_reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         a_rw = vt[i].rw; a_wsel = vt[i].wsel; a_w = vt[i].w;
         a_rsel0 = vt[i].rsel0; a_rsel1 = vt[i].rsel1; a_clr = vt[i].clr;
         push_exp($sformatf("vec%0d", i), 16'(vt[i].e0), 16'(vt[i].e1), vt[i].eb, vt[i].ed);
         observe(0);
      end
      a_rw = 1'b0; a_clr = 1'b0;

      drive_z("zr_wr0",  1'b1, 2'd0, 8'hEE, 2'd0, 2'd1, 8'h00, 8'h00, 1'b0);
      drive_z("zr_wr1",  1'b1, 2'd1, 8'h5A, 2'd0, 2'd1, 8'h00, BYP ? 8'h5A : 8'h00, 1'b0);
      drive_z("zr_read", 1'b0, 2'd0, 8'h00, 2'd0, 2'd1, 8'h00, 8'h5A, 1'b0);

      //      name          rst   rw    wsel  w         rs0   rs1   clr   e0        e1                       busy  drop
      drive_b("wide_oob",   1'b0, 1'b1, 3'd7, 16'h1234, 3'd6, 3'd7, 1'b0, 16'h0000, 16'h0000,                1'b0, 1'b0);
      drive_b("wide_wr4",   1'b0, 1'b1, 3'd4, 16'hBEEF, 3'd6, 3'd4, 1'b0, 16'h0000, BYP ? 16'hBEEF : 16'h0, 1'b0, 1'b1);
      drive_b("wide_wr0",   1'b0, 1'b1, 3'd0, 16'hCAFE, 3'd4, 3'd5, 1'b0, 16'hBEEF, 16'h0000,                1'b0, 1'b0);
      drive_b("wide_clr",   1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd4, 1'b1, 16'hCAFE, 16'hBEEF,                1'b0, 1'b0);
      drive_b("wide_c1",    1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd4, 1'b0, 16'hCAFE, 16'hBEEF,                1'b1, 1'b0);
      drive_b("wide_rst",   1'b1, 1'b1, 3'd7, 16'h0000, 3'd0, 3'd4, 1'b0, 16'h0000, 16'hBEEF,                1'b1, 1'b0);
      drive_b("wide_post",  1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0, 1'b0, 16'h0000, 16'h0000,                1'b0, 1'b0);
      drive_b("wide_post2", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, 1'b0, 16'h0000, 16'h0000,                1'b0, 1'b0);
      drive_b("wide_clr2",  1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd4, 1'b1, 16'h0000, 16'h0000,                1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         drive_b($sformatf("wide_busy%0d", c), 1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0,
                 16'h0000, 16'h0000, 1'b1, 1'b0);
      end
      drive_b("wide_done",  1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 16'h0000,                1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
